// File: rtl/ser_tx_pkg.sv
// Shared types and constants for the serial transmit sequencer.
package ser_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;

endpackage

// File: rtl/flex_counter.sv
// Rollover counter: counts 0..rollover_val-1 while enabled, flags the last count combinationally.
// Latency: flag in the same cycle the count reaches rollover_val-1; no backpressure.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  assign rollover_flag = count_enable && (count_q == (rollover_val - ONE));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = rollover_flag ? '0 : (count_q + ONE);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register; resets to and back-fills with 1s so an idle line reads high.
// Latency: load/shift take effect on the next clock; load has priority over shift.
module flex_pts_sr #(
  parameter int NUM_BITS  = 4,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                load_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_enable) begin
      sr_d = parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB) sr_d = {sr_q[NUM_BITS-2:0], 1'b1};
      else           sr_d = {1'b1, sr_q[NUM_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sr_q <= '1;
    else        sr_q <= sr_d;
  end

  assign serial_out = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];

endmodule

// File: rtl/ser_tx_ctrl.sv
// UART-style transmit sequencer driving load/shift of an external LSB-first shift register.
// Accepts one word per frame; tx_ready only in IDLE, so requesters hold tx_valid until taken.
module ser_tx_ctrl
  import ser_tx_pkg::*;
#(
  parameter  int DATA_BITS    = 8,
  parameter  int CLKS_PER_BIT = 10,
  parameter  int PARITY_EN    = PAR_NONE,
  localparam int FRAME_BITS   = DATA_BITS + 2 + PARITY_EN
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  tx_valid,
  input  logic [DATA_BITS-1:0]  tx_data,
  output logic                  tx_ready,
  output logic                  load_enable,
  output logic                  shift_enable,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CPB_VAL  = CNT_W'(CLKS_PER_BIT);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  state_t            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              bit_tick;

  // The frame is built straight from tx_data; the SR captures it in the accept cycle.
  generate
    if (PARITY_EN == PAR_EVEN) begin : g_par
      assign frame_out = {1'b1, ^tx_data, tx_data, 1'b0};
    end else begin : g_nopar
      assign frame_out = {1'b1, tx_data, 1'b0};
    end
  endgenerate

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (load_enable),
    .count_enable (state_q == SEND),
    .rollover_val (CPB_VAL),
    .rollover_flag(bit_tick)
  );

  assign shift_enable = bit_tick;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_ready    = 1'b0;
    load_enable = 1'b0;
    busy        = 1'b0;
    tx_done     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          load_enable = 1'b1;
          bit_cnt_d   = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        busy = 1'b1;
        if (bit_tick) begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
          if (bit_cnt_q == LAST_BIT) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        tx_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_ser_tx_ctrl.sv
// Scoreboard bench: three controller+SR pairs (CPB=4, CPB=4 with parity, CPB=1).
module tb_ser_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst;
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] v, rdy, le, se, bsy, dn, so;
  logic [7:0] d [3];
  logic [9:0] fo0, fo2;
  logic [10:0] fo1;
  logic [10:0] fo [3];

  always_comb begin
    fo[0] = {1'b0, fo0};
    fo[1] = fo1;
    fo[2] = {1'b0, fo2};
  end

  ser_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_ctl0 (
    .clk(clk), .n_rst(n_rst), .tx_valid(v[0]), .tx_data(d[0]), .tx_ready(rdy[0]),
    .load_enable(le[0]), .shift_enable(se[0]), .frame_out(fo0), .busy(bsy[0]), .tx_done(dn[0]));
  flex_pts_sr #(.NUM_BITS(10), .SHIFT_MSB(1'b0)) u_sr0 (
    .clk(clk), .n_rst(n_rst), .shift_enable(se[0]), .load_enable(le[0]),
    .parallel_in(fo0), .serial_out(so[0]));

  ser_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_ctl1 (
    .clk(clk), .n_rst(n_rst), .tx_valid(v[1]), .tx_data(d[1]), .tx_ready(rdy[1]),
    .load_enable(le[1]), .shift_enable(se[1]), .frame_out(fo1), .busy(bsy[1]), .tx_done(dn[1]));
  flex_pts_sr #(.NUM_BITS(11), .SHIFT_MSB(1'b0)) u_sr1 (
    .clk(clk), .n_rst(n_rst), .shift_enable(se[1]), .load_enable(le[1]),
    .parallel_in(fo1), .serial_out(so[1]));

  ser_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_ctl2 (
    .clk(clk), .n_rst(n_rst), .tx_valid(v[2]), .tx_data(d[2]), .tx_ready(rdy[2]),
    .load_enable(le[2]), .shift_enable(se[2]), .frame_out(fo2), .busy(bsy[2]), .tx_done(dn[2]));
  flex_pts_sr #(.NUM_BITS(10), .SHIFT_MSB(1'b0)) u_sr2 (
    .clk(clk), .n_rst(n_rst), .shift_enable(se[2]), .load_enable(le[2]),
    .parallel_in(fo2), .serial_out(so[2]));

  typedef struct {
    int          inst;
    int          t;
    logic [10:0] val;
  } ev_t;

  ev_t q_load[$];
  ev_t q_shift[$];
  ev_t q_done[$];
  bit  exp_line [int];
  int  n_tests = 0;
  int  n_fail  = 0;
  localparam int NO_LIMIT = 32'h7fff_ffff;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected events for one frame; anything at or after 'limit' is dropped (reset abort).
  task automatic push_frame(input int inst, input int t0, input logic [10:0] frame,
                            input int nbits, input int cpb, input int limit);
    ev_t e;
    e.inst = inst; e.t = t0; e.val = frame;
    q_load.push_back(e);
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < cpb; c++) begin
        if (t0 + 1 + k * cpb + c < limit) exp_line[(t0 + 1 + k * cpb + c) * 4 + inst] = frame[k];
      end
      e.t = t0 + (k + 1) * cpb;
      if (e.t < limit) q_shift.push_back(e);
    end
    e.t = t0 + 1 + nbits * cpb;
    if (e.t < limit) q_done.push_back(e);
  endtask

  task automatic pop_ev(input int kind, input int i);
    ev_t e;
    int  sz;
    string nm;
    case (kind)
      0: begin sz = q_load.size();  nm = "load";  end
      1: begin sz = q_shift.size(); nm = "shift"; end
      default: begin sz = q_done.size(); nm = "done"; end
    endcase
    if (sz == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_%s: inst %0d got pulse expected none (cycle %0d)", nm, i, cyc);
      return;
    end
    case (kind)
      0: e = q_load.pop_front();
      1: e = q_shift.pop_front();
      default: e = q_done.pop_front();
    endcase
    check({nm, "_inst"}, i, e.inst);
    check({nm, "_time"}, cyc, e.t);
    if (kind == 0) check("frame_out", fo[i], e.val);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check("serial_out", so[i], exp_line.exists(cyc * 4 + i) ? exp_line[cyc * 4 + i] : 1'b1);
      check("load_shift_excl", le[i] & se[i], 0);
      if (le[i]) pop_ev(0, i);
      if (se[i]) pop_ev(1, i);
      if (dn[i]) pop_ev(2, i);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  initial begin
    int c;
    n_rst = 1'b0;
    v     = '0;
    for (int i = 0; i < 3; i++) d[i] = 8'h00;
    tick(2);
    @(negedge clk);
    check("rst_tx_ready", rdy[0], 1);
    check("rst_load", le[0], 0);
    check("rst_shift", se[0], 0);
    check("rst_busy", bsy[0], 0);
    check("rst_done", dn[0], 0);
    check("rst_serial", so[0], 1);
    tick(1);
    n_rst = 1'b1;
    tick(2);

    // Single frame 0xA5; data scrambled after T0 since no copy is kept.
    c = cyc;
    v[0] = 1'b1; d[0] = 8'hA5;
    push_frame(0, c, 11'h34A, 10, 4, NO_LIMIT);
    tick(1);
    v[0] = 1'b0; d[0] = 8'h00;
    wait_until(c + 41);
    @(negedge clk);
    check("ready_in_done", rdy[0], 0);
    check("busy_in_done", bsy[0], 1);
    wait_until(c + 42);
    @(negedge clk);
    check("ready_after_done", rdy[0], 1);
    check("busy_after_done", bsy[0], 0);
    tick(3);

    // Back-to-back with tx_valid held: second load exactly at T1+41.
    c = cyc;
    v[0] = 1'b1; d[0] = 8'h00;
    push_frame(0, c, 11'h200, 10, 4, NO_LIMIT);
    push_frame(0, c + 42, 11'h3FE, 10, 4, NO_LIMIT);
    tick(1);
    d[0] = 8'hFF;
    wait_until(c + 43);
    v[0] = 1'b0;
    wait_until(c + 86);

    // Even parity.
    c = cyc;
    v[1] = 1'b1; d[1] = 8'h07;
    push_frame(1, c, 11'h60E, 11, 4, NO_LIMIT);
    tick(1);
    v[1] = 1'b0;
    wait_until(c + 48);

    // Reset at T1+13, then a fresh frame.
    c = cyc;
    v[0] = 1'b1; d[0] = 8'hA5;
    push_frame(0, c, 11'h34A, 10, 4, c + 14);
    tick(1);
    v[0] = 1'b0;
    wait_until(c + 14);
    n_rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", bsy[0], 0);
    check("midrst_shift", se[0], 0);
    check("midrst_serial", so[0], 1);
    tick(2);
    n_rst = 1'b1;
    @(negedge clk);
    check("postrst_ready", rdy[0], 1);
    tick(1);
    c = cyc;
    v[0] = 1'b1; d[0] = 8'h5A;
    push_frame(0, c, 11'h2B4, 10, 4, NO_LIMIT);
    tick(1);
    v[0] = 1'b0;
    wait_until(c + 45);

    // One clock per bit: shift on every SEND cycle.
    c = cyc;
    v[2] = 1'b1; d[2] = 8'h3C;
    push_frame(2, c, 11'h278, 10, 1, NO_LIMIT);
    tick(1);
    v[2] = 1'b0;
    wait_until(c + 14);

    tick(3);
    check("pending_load", q_load.size(), 0);
    check("pending_shift", q_shift.size(), 0);
    check("pending_done", q_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
